// File: rtl/tim_apb_arbiter.sv
// APB master that shares the timer slave port between two requesters.
// Round-robin arbitration, SETUP/ACCESS sequencing and an ACCESS-phase watchdog.
module tim_apb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  rq0_req,
  input  logic                  rq0_write,
  input  logic [ADDR_WIDTH-1:0] rq0_addr,
  input  logic [DATA_WIDTH-1:0] rq0_wdata,
  output logic                  rq0_done,
  input  logic                  rq1_req,
  input  logic                  rq1_write,
  input  logic [ADDR_WIDTH-1:0] rq1_addr,
  input  logic [DATA_WIDTH-1:0] rq1_wdata,
  output logic                  rq1_done,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  tim_psel,
  output logic                  tim_penable,
  output logic                  tim_pwrite,
  output logic [ADDR_WIDTH-1:0] tim_paddr,
  output logic [DATA_WIDTH-1:0] tim_pwdata,
  input  logic [DATA_WIDTH-1:0] tim_prdata,
  input  logic                  tim_pready,
  input  logic                  tim_pslverr
);

  // Counter holds the number of ACCESS cycles already spent, 0 .. TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             grant_q;
  logic             last_q;
  logic             pick;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    pick = rq1_req && (!rq0_req || !last_q);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      rq0_done    <= 1'b0;
      rq1_done    <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
      tim_psel    <= 1'b0;
      tim_penable <= 1'b0;
      tim_pwrite  <= 1'b0;
      tim_paddr   <= '0;
      tim_pwdata  <= '0;
    end else begin
      rq0_done <= 1'b0;
      rq1_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rq0_req || rq1_req) begin
            state_q    <= StSetup;
            grant_q    <= pick;
            last_q     <= pick;
            cnt_q      <= '0;
            busy       <= 1'b1;
            tim_psel   <= 1'b1;
            tim_pwrite <= pick ? rq1_write : rq0_write;
            tim_paddr  <= pick ? rq1_addr  : rq0_addr;
            tim_pwdata <= pick ? rq1_wdata : rq0_wdata;
          end
        end
        StSetup: begin
          state_q     <= StAccess;
          tim_penable <= 1'b1;
        end
        StAccess: begin
          if (tim_pready) begin
            state_q     <= StDone;
            tim_psel    <= 1'b0;
            tim_penable <= 1'b0;
            rsp_rdata   <= tim_pwrite ? '0 : tim_prdata;
            rsp_err     <= tim_pslverr;
            rq0_done    <= ~grant_q;
            rq1_done    <= grant_q;
          end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
            // Watchdog abort: slave never answered.
            state_q     <= StDone;
            tim_psel    <= 1'b0;
            tim_penable <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rq0_done    <= ~grant_q;
            rq1_done    <= grant_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tim_apb_arbiter.sv
// Bench for tim_apb_arbiter: timestamp-based transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized requesters and slave.
module tb_tim_apb_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          rq0_req, rq0_write, rq0_done;
  logic [AW-1:0] rq0_addr;
  logic [DW-1:0] rq0_wdata;
  logic          rq1_req, rq1_write, rq1_done;
  logic [AW-1:0] rq1_addr;
  logic [DW-1:0] rq1_wdata;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, busy;
  logic          tim_psel, tim_penable, tim_pwrite;
  logic [AW-1:0] tim_paddr;
  logic [DW-1:0] tim_pwdata, tim_prdata;
  logic          tim_pready, tim_pslverr;

  // Second instance with the watchdog disabled.
  logic          b_req, b_pready, b_done0, b_done1, b_err, b_busy;
  logic          b_psel, b_penable, b_pwrite;
  logic [AW-1:0] b_paddr;
  logic [DW-1:0] b_pwdata, b_rdata;

  always #5 sys_clk = ~sys_clk;

  tim_apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .rq0_req(rq0_req), .rq0_write(rq0_write), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_done(rq0_done),
    .rq1_req(rq1_req), .rq1_write(rq1_write), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_done(rq1_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_prdata(tim_prdata),
    .tim_pready(tim_pready), .tim_pslverr(tim_pslverr)
  );

  tim_apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) dut_nto (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .rq0_req(b_req), .rq0_write(1'b0), .rq0_addr(12'h040), .rq0_wdata(32'h0),
    .rq0_done(b_done0),
    .rq1_req(1'b0), .rq1_write(1'b0), .rq1_addr(12'h0), .rq1_wdata(32'h0),
    .rq1_done(b_done1),
    .rsp_rdata(b_rdata), .rsp_err(b_err), .busy(b_busy),
    .tim_psel(b_psel), .tim_penable(b_penable), .tim_pwrite(b_pwrite),
    .tim_paddr(b_paddr), .tim_pwdata(b_pwdata), .tim_prdata(32'h0000_C0DE),
    .tim_pready(b_pready), .tim_pslverr(1'b0)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired without the expected event (t=%0t)", name, $time);
  endtask

  // Model: a transaction is granted at edge m_g; SETUP is the cycle after it, ACCESS cycles
  // follow until pready is seen or TO ACCESS cycles elapse; the next cycle is the done cycle.
  int unsigned   edge_n = 0;
  int unsigned   m_g = 0;
  int unsigned   m_free = 0;
  bit            m_act = 1'b0;
  bit            m_done = 1'b0;
  bit            m_who = 1'b0;
  bit            m_last = 1'b1;
  bit            m_wr = 1'b0;
  bit            m_err = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [DW-1:0] m_rdata = '0;

  task automatic model_step();
    m_done = 1'b0;
    if (sys_rst) begin
      m_act  = 1'b0;
      m_last = 1'b1;
      m_free = 0;
    end else if (m_act) begin
      if (edge_n - m_g >= 2) begin
        if (tim_pready) begin
          m_rdata = m_wr ? '0 : tim_prdata;
          m_err   = tim_pslverr;
          m_done  = 1'b1;
        end else if (TO != 0 && edge_n - m_g - 1 == TO) begin
          m_rdata = '0;
          m_err   = 1'b1;
          m_done  = 1'b1;
        end
        if (m_done) begin
          m_act  = 1'b0;
          m_free = edge_n + 2;  // done cycle, then one idle cycle before sampling
        end
      end
    end else if (edge_n >= m_free && (rq0_req || rq1_req)) begin
      m_who  = (rq0_req && rq1_req) ? !m_last : rq1_req;
      m_last = m_who;
      m_wr   = m_who ? rq1_write : rq0_write;
      m_addr = m_who ? rq1_addr  : rq0_addr;
      m_wd   = m_who ? rq1_wdata : rq0_wdata;
      m_g    = edge_n;
      m_act  = 1'b1;
    end
  endtask

  initial begin : compare
    forever begin
      @(posedge sys_clk);
      edge_n++;
      model_step();
      #1;
      check("cyc_busy", busy, m_act || m_done);
      check("cyc_psel", tim_psel, m_act);
      check("cyc_penable", tim_penable, m_act && (edge_n - m_g >= 1));
      check("cyc_rq0_done", rq0_done, m_done && !m_who);
      check("cyc_rq1_done", rq1_done, m_done && m_who);
      if (m_act) begin
        check("cyc_pwrite", tim_pwrite, m_wr);
        check("cyc_paddr", tim_paddr, m_addr);
        check("cyc_pwdata", tim_pwdata, m_wd);
      end
      if (m_done) begin
        check("cyc_rdata", rsp_rdata, m_rdata);
        check("cyc_err", rsp_err, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  // Runs one transaction from an idle arbiter; slave inserts `waits` wait states.
  task automatic do_txn(input bit who, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int waits, input logic [DW-1:0] rd,
                        input bit err, output int lat, output int psel_n, output int pen_n,
                        output logic [DW-1:0] got_rd, output logic got_err);
    int acc = 0;
    lat = 0; psel_n = 0; pen_n = 0; got_rd = '0; got_err = 1'b0;
    tick();
    if (who) begin
      rq1_req = 1'b1; rq1_write = wr; rq1_addr = a; rq1_wdata = d;
    end else begin
      rq0_req = 1'b1; rq0_write = wr; rq0_addr = a; rq0_wdata = d;
    end
    tim_pready = 1'b0; tim_prdata = rd; tim_pslverr = err;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      tick();
      if (tim_psel) begin
        psel_n++;
        check("txn_paddr", tim_paddr, a);
        check("txn_pwrite", tim_pwrite, wr);
      end
      if (tim_penable) pen_n++;
      if (tim_psel && tim_penable) acc++;
      check("txn_other_done", who ? rq0_done : rq1_done, 1'b0);
      if (who ? rq1_done : rq0_done) begin
        lat = c; got_rd = rsp_rdata; got_err = rsp_err;
      end
      tim_pready = tim_psel && tim_penable && (acc > waits);
    end
    rq0_req = 1'b0; rq1_req = 1'b0; tim_pready = 1'b0;
    if (lat == 0) fail_bound("txn_done");
  endtask

  int            lat, ps_n, pe_n;
  logic [DW-1:0] grd;
  logic          gerr;
  int            stall;

  initial begin : stim
    sys_rst = 1'b1;
    rq0_req = 0; rq0_write = 0; rq0_addr = '0; rq0_wdata = '0;
    rq1_req = 0; rq1_write = 0; rq1_addr = '0; rq1_wdata = '0;
    tim_prdata = '0; tim_pready = 0; tim_pslverr = 0;
    b_req = 0; b_pready = 0;
    repeat (3) tick();
    check("rst_psel", tim_psel, 1'b0);
    check("rst_penable", tim_penable, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", {rq0_done, rq1_done}, 2'b00);
    check("rst_paddr", tim_paddr, '0);
    check("rst_pwdata", tim_pwdata, '0);
    check("rst_rdata_err", {rsp_rdata, rsp_err}, '0);
    sys_rst = 1'b0;

    // Single zero-wait write from rq0.
    do_txn(1'b0, 1'b1, 12'h004, 32'hA5A5_0001, 0, 32'h0, 1'b0, lat, ps_n, pe_n, grd, gerr);
    check("wr_latency", lat, 3);
    check("wr_psel_cycles", ps_n, 2);
    check("wr_penable_cycles", pe_n, 1);
    check("wr_err", gerr, 1'b0);
    check("wr_rdata", grd, 32'h0);

    // Read from rq1 with two wait states.
    do_txn(1'b1, 1'b0, 12'h010, 32'h0, 2, 32'h0000_1234, 1'b0, lat, ps_n, pe_n, grd, gerr);
    check("rd_latency", lat, 5);
    check("rd_rdata", grd, 32'h0000_1234);
    check("rd_err", gerr, 1'b0);
    check("rd_penable_cycles", pe_n, 3);

    // Contention: both requesters keep asking; grants must alternate starting with rq0.
    begin
      int order[4];
      int nd = 0;
      int gap = 0;
      int min_gap = 1000;
      bit seen = 1'b0;
      tick();
      rq0_req = 1; rq0_write = 1; rq0_addr = 12'h100; rq0_wdata = 32'h1111_0000;
      rq1_req = 1; rq1_write = 0; rq1_addr = 12'h200; rq1_wdata = 32'h0;
      tim_pready = 1; tim_pslverr = 0; tim_prdata = 32'h0000_0077;
      for (int c = 0; c < 60 && nd < 4; c++) begin
        tick();
        if (tim_psel) begin
          if (seen && gap > 0 && gap < min_gap) min_gap = gap;
          seen = 1'b1; gap = 0;
        end else if (seen) begin
          gap++;
        end
        if (rq0_done) begin
          order[nd] = 0; nd++; rq0_req = 0;
        end else if (!rq0_req) begin
          rq0_req = 1;
        end
        if (rq1_done) begin
          order[nd] = 1; nd++; rq1_req = 0;
        end else if (!rq1_req) begin
          rq1_req = 1;
        end
      end
      rq0_req = 0; rq1_req = 0; tim_pready = 0;
      if (nd < 4) fail_bound("cont_four_done");
      else begin
        check("cont_grant0", order[0], 0);
        check("cont_grant1", order[1], 1);
        check("cont_grant2", order[2], 0);
        check("cont_grant3", order[3], 1);
        check("cont_min_gap", min_gap, 2);
      end
    end

    // Slave error, then a clean transaction.
    do_txn(1'b0, 1'b1, 12'h008, 32'h0000_0055, 0, 32'h0, 1'b1, lat, ps_n, pe_n, grd, gerr);
    check("slverr_err", gerr, 1'b1);
    do_txn(1'b1, 1'b0, 12'h00C, 32'h0, 1, 32'h0000_BEEF, 1'b0, lat, ps_n, pe_n, grd, gerr);
    check("after_err_err", gerr, 1'b0);
    check("after_err_rdata", grd, 32'h0000_BEEF);
    check("after_err_latency", lat, 4);

    // Watchdog: slave never answers.
    do_txn(1'b0, 1'b0, 12'h020, 32'h0, 1000, 32'hDEAD_DEAD, 1'b0, lat, ps_n, pe_n, grd, gerr);
    check("to_latency", lat, 18);
    check("to_penable_cycles", pe_n, 16);
    check("to_err", gerr, 1'b1);
    check("to_rdata", grd, 32'h0);

    // Watchdog disabled: waits indefinitely, then completes when pready comes.
    begin
      int seen_done = 0;
      int blat = 0;
      tick();
      b_req = 1'b1; b_pready = 1'b0;
      repeat (40) begin
        tick();
        if (b_done0) seen_done++;
      end
      check("nto_psel_held", b_psel, 1'b1);
      check("nto_penable_held", b_penable, 1'b1);
      check("nto_no_done", seen_done, 0);
      b_pready = 1'b1;
      for (int c = 1; c <= 5 && blat == 0; c++) begin
        tick();
        if (b_done0) begin
          blat = c;
          check("nto_rdata", b_rdata, 32'h0000_C0DE);
          check("nto_err", b_err, 1'b0);
        end
      end
      b_req = 1'b0; b_pready = 1'b0;
      if (blat == 0) fail_bound("nto_done");
      else check("nto_done_latency", blat, 1);
    end

    // Asynchronous reset during a wait state.
    tick();
    rq0_req = 1; rq0_write = 0; rq0_addr = 12'h030; tim_pready = 0;
    repeat (3) tick();
    check("arst_pre_penable", tim_penable, 1'b1);
    #3;
    sys_rst = 1'b1;
    #1;
    check("arst_psel", tim_psel, 1'b0);
    check("arst_penable", tim_penable, 1'b0);
    check("arst_busy", busy, 1'b0);
    rq0_req = 0;
    repeat (3) begin
      tick();
      check("arst_no_done", {rq0_done, rq1_done}, 2'b00);
    end
    sys_rst = 1'b0;
    do_txn(1'b0, 1'b1, 12'h00C, 32'h1234_5678, 0, 32'h0, 1'b0, lat, ps_n, pe_n, grd, gerr);
    check("arst_after_latency", lat, 3);
    check("arst_after_err", gerr, 1'b0);

    // Randomized requesters and slave; the compare process does the checking.
    stall = 0;
    repeat (3000) begin
      tick();
      if (rq0_done) rq0_req = 0;
      else if (!rq0_req && $urandom_range(0, 3) == 0) begin
        rq0_req = 1; rq0_write = 1'($urandom_range(0, 1));
        rq0_addr = AW'($urandom); rq0_wdata = $urandom;
      end else if (rq0_req && $urandom_range(0, 7) == 0) begin
        rq0_write = 1'($urandom_range(0, 1)); rq0_addr = AW'($urandom); rq0_wdata = $urandom;
      end
      if (rq1_done) rq1_req = 0;
      else if (!rq1_req && $urandom_range(0, 3) == 0) begin
        rq1_req = 1; rq1_write = 1'($urandom_range(0, 1));
        rq1_addr = AW'($urandom); rq1_wdata = $urandom;
      end else if (rq1_req && $urandom_range(0, 7) == 0) begin
        rq1_write = 1'($urandom_range(0, 1)); rq1_addr = AW'($urandom); rq1_wdata = $urandom;
      end
      if (stall > 0) begin
        tim_pready = 0; stall--;
      end else begin
        if ($urandom_range(0, 149) == 0) stall = 20;
        tim_pready = ($urandom_range(0, 2) != 0);
      end
      tim_prdata = $urandom;
      tim_pslverr = ($urandom_range(0, 3) == 0);
    end
    rq0_req = 0; rq1_req = 0; tim_pready = 1;
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
